// File: rtl/seq_divider.sv
// Sequential restoring divider: unsigned quotient/remainder by iterated shift/subtract
// over a combined {partial remainder, quotient} register, with a start/done handshake.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_SUB   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [2*WIDTH:0] r_reg, r_nxt;
    logic [WIDTH-1:0] b_reg, b_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             dz_reg, dz_nxt;
    logic [WIDTH+1:0] diff;

    // Extra top bit of diff is the borrow: set means A < B, so restore.
    assign diff = {1'b0, r_reg[2*WIDTH:WIDTH]} - {2'b00, b_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            r_reg  <= '0;
            b_reg  <= '0;
            count  <= '0;
            dz_reg <= 1'b0;
        end else begin
            state  <= state_nxt;
            r_reg  <= r_nxt;
            b_reg  <= b_nxt;
            count  <= count_nxt;
            dz_reg <= dz_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_nxt     = r_reg;
        b_nxt     = b_reg;
        count_nxt = count;
        dz_nxt    = dz_reg;
        case (state)
            S_IDLE: begin
                if (start) begin
                    b_nxt     = divisor;
                    count_nxt = '0;
                    if (divisor == '0) begin
                        // Preload the divide-by-zero answer so DONE reads it straight from R.
                        r_nxt     = {1'b0, dividend, {WIDTH{1'b1}}};
                        dz_nxt    = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        r_nxt     = {{(WIDTH+1){1'b0}}, dividend};
                        dz_nxt    = 1'b0;
                        state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                r_nxt     = {r_reg[2*WIDTH-1:0], 1'b0};
                state_nxt = S_SUB;
            end
            S_SUB: begin
                if (!diff[WIDTH+1]) begin
                    r_nxt = {diff[WIDTH:0], r_reg[WIDTH-1:1], 1'b1};
                end
                count_nxt = count + CW'(1);
                if (count == CW'(WIDTH - 1)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_SHIFT;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign quotient    = r_reg[WIDTH-1:0];
    assign remainder   = r_reg[2*WIDTH-1:WIDTH];
    assign div_by_zero = dz_reg;
    assign dbg_state   = state;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (WIDTH=4): table vectors, handshake/reset corner sequences
// and an exhaustive sweep, checked through an expected-result queue.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    // expected {quotient, remainder, div_by_zero}
    logic [2*W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs[8];

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at E0+#1; waits for done, checks latency, pops and compares.
    task automatic wait_done(input int exp_lat);
        int lat;
        logic [2*W:0] e;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("busy_at_done", busy, 1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: done with no expected result queued");
        end else begin
            e = exp_q.pop_front();
            check("result", {quotient, remainder, div_by_zero}, e);
        end
    endtask

    // Precondition: DUT idle, time is posedge+#1. Leaves DUT back in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back({eq, er, edz});
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = $urandom_range(0, 15);
        divisor  = $urandom_range(0, 15);
        wait_done((b == 0) ? 1 : 2*W + 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int dc;
        logic [W-1:0] a, b;

        vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
        vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
        vecs[2] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
        vecs[3] = '{4'd7,  4'd9,  4'd0,  4'd7, 1'b0};
        vecs[4] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
        vecs[5] = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1};
        vecs[6] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0};
        vecs[7] = '{4'd12, 4'd5,  4'd2,  4'd2, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
        end

        // results held with start low
        run_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("hold_result", {quotient, remainder, div_by_zero}, {4'd4, 4'd1, 1'b0});
            check("hold_idle", {busy, done}, 2'b00);
            @(posedge clk); #1;
        end

        // start held high, operands changed while busy
        dividend = 4'd14;
        divisor  = 4'd4;
        start    = 1'b1;
        exp_q.push_back({4'd3, 4'd2, 1'b0});
        @(posedge clk); #1;
        dividend = 4'd1;
        divisor  = 4'd1;
        wait_done(2*W + 1);
        exp_q.push_back({4'd1, 4'd0, 1'b0});
        @(posedge clk); #1;
        check("b2b_idle_gap", busy, 0);
        @(posedge clk); #1;
        check("b2b_accept", busy, 1);
        start = 1'b0;
        wait_done(2*W + 1);
        @(posedge clk); #1;

        // reset three edges after accept aborts the operation
        dividend = 4'd11;
        divisor  = 4'd2;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dc = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_outputs", {busy, done, quotient, remainder, div_by_zero}, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midreset_no_done", done_cnt, dc);
        check("midreset_idle", {busy, quotient, remainder, div_by_zero}, '0);
        run_op(4'd11, 4'd2, 4'd5, 4'd1, 1'b0);

        // exhaustive sweep against integer / and %
        for (int i = 0; i < 256; i++) begin
            a = W'(i >> 4);
            b = W'(i & 15);
            if (b == 0) run_op(a, b, 4'hF, a, 1'b1);
            else        run_op(a, b, a / b, a % b, 1'b0);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
